// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the ping-pong audio sample writer:
//   - default sample width, channel count and half-buffer depth
//   - serializer state encoding
//   - elaboration-time sanity check of the buffer geometry
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_BUF_DEPTH  = 2048;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // A half must hold a whole number of frames so that a frame never
  // straddles the ping/pong boundary, and the depth must be a power of two
  // so the word pointer wraps naturally.
  function automatic bit depth_ok(input int depth, input int channels);
    return (channels >= 1) && (channels <= 8) && (depth > 0) &&
           ((depth & (depth - 1)) == 0) && ((depth % channels) == 0);
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
// Latches one multi-channel PCM frame and presents its samples one word per
// cycle, channel 0 first, for CHANNELS consecutive cycles.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : accept the frame on frame_i (only honoured while idle)
//   frame_i  : packed frame, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//   busy_o   : a word is being presented this cycle
//   last_o   : the word presented this cycle is the final channel
//   word_o   : current sample word (zero while idle)
// -----------------------------------------------------------------------------
module frame_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] frame_i,
  output logic                           busy_o,
  output logic                           last_o,
  output logic [DATA_WIDTH-1:0]          word_o
);

  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHANNELS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] frame_q [CHANNELS];
  logic [DATA_WIDTH-1:0] frame_d [CHANNELS];

  // Next-state logic: latch the frame on start, then step the channel index
  // once per cycle until the last channel has been presented.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          for (int n = 0; n < CHANNELS; n++) begin
            frame_d[n] = frame_i[n*DATA_WIDTH +: DATA_WIDTH];
          end
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, channel index and frame register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        frame_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Outputs depend only on registers, so the write strobes downstream never
  // see a combinational path from the frame input.
  always_comb begin
    busy_o = (state_q == WRITE);
    last_o = busy_o && (cnt_q == LAST_IDX);
    word_o = busy_o ? frame_q[cnt_q] : '0;
  end

endmodule

// File: rtl/audio_pingpong_writer.sv
// -----------------------------------------------------------------------------
// audio_pingpong_writer
// Writes multi-channel PCM frames into a dual-half (ping/pong) RAM, one word
// per cycle, and hands completed halves to a consumer through full/release
// handshakes. Frames that cannot be stored are dropped and flagged.
// Ports:
//   HCLK, HRESETn            : clock, asynchronous active-low reset
//   EN                       : capture enable
//   in_valid, in_data        : one-cycle frame strobe and packed frame
//   ram_addr, ram_wdata      : word address within active half, write data
//   ping_we, pong_we         : write strobe for each half
//   active_buf               : half being filled (0 = ping, 1 = pong)
//   ping_full, pong_full     : half complete, awaiting consumer
//   ping_release, pong_release : consumer has drained the half
//   overrun, overrun_clr     : sticky drop flag and its clear
// -----------------------------------------------------------------------------
module audio_pingpong_writer
  import audio_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int CHANNELS   = DEF_CHANNELS,
  parameter  int BUF_DEPTH  = DEF_BUF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           EN,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_wdata,
  output logic                           ping_we,
  output logic                           pong_we,
  output logic                           active_buf,
  output logic                           ping_full,
  output logic                           pong_full,
  input  logic                           ping_release,
  input  logic                           pong_release,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  if (!depth_ok(BUF_DEPTH, CHANNELS)) begin : g_bad_cfg
    $error("audio_pingpong_writer: BUF_DEPTH must be a power of two and a multiple of CHANNELS (1..8)");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  active_q, active_d;
  logic                  ping_full_q, ping_full_d;
  logic                  pong_full_q, pong_full_d;
  logic                  overrun_q, overrun_d;

  logic                  busy;
  logic                  last;
  logic [DATA_WIDTH-1:0] word;
  logic                  active_full;
  logic                  accept;
  logic                  drop;
  logic                  half_done;

  frame_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS)
  ) u_serializer (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .start_i (accept),
    .frame_i (in_data),
    .busy_o  (busy),
    .last_o  (last),
    .word_o  (word)
  );

  // Frame admission. A frame is taken only when the serializer is idle and
  // the half being filled is free; while capture is enabled any other strobe
  // is a lost frame. With capture disabled strobes are ignored silently.
  always_comb begin
    active_full = active_q ? pong_full_q : ping_full_q;
    accept      = in_valid && EN && !busy && !active_full;
    drop        = in_valid && EN && (busy || active_full);
    half_done   = busy && last && (ptr_q == LAST_ADDR);
  end

  // Pointer, half select, full flags and overrun. The pointer only moves on
  // written words, so pausing capture leaves the fill position intact. A
  // set of a full flag wins over a release in the same cycle: the half was
  // not yet full, so that release is meaningless.
  always_comb begin
    ptr_d       = ptr_q;
    active_d    = active_q;
    ping_full_d = ping_full_q;
    pong_full_d = pong_full_q;
    overrun_d   = overrun_q;

    if (busy) begin
      if (half_done) begin
        ptr_d    = '0;
        active_d = !active_q;
      end else begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
      end
    end

    if (half_done && !active_q) begin
      ping_full_d = 1'b1;
    end else if (ping_release) begin
      ping_full_d = 1'b0;
    end

    if (half_done && active_q) begin
      pong_full_d = 1'b1;
    end else if (pong_release) begin
      pong_full_d = 1'b0;
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q       <= '0;
      active_q    <= 1'b0;
      ping_full_q <= 1'b0;
      pong_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      active_q    <= active_d;
      ping_full_q <= ping_full_d;
      pong_full_q <= pong_full_d;
      overrun_q   <= overrun_d;
    end
  end

  // All outputs are decoded from registers only.
  always_comb begin
    ram_addr   = ptr_q;
    ram_wdata  = word;
    ping_we    = busy && !active_q;
    pong_we    = busy && active_q;
    active_buf = active_q;
    ping_full  = ping_full_q;
    pong_full  = pong_full_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_audio_pingpong_writer.sv
// -----------------------------------------------------------------------------
// tb_audio_pingpong_writer
// Directed bench for audio_pingpong_writer with CHANNELS=2, BUF_DEPTH=8.
// Expected RAM writes are queued when a frame is driven and compared when the
// DUT raises a write strobe; status flags are checked at directed points.
// -----------------------------------------------------------------------------
module tb_audio_pingpong_writer;

  localparam int DW    = 16;
  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic          isPong;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic             HCLK;
  logic             HRESETn;
  logic             EN;
  logic             in_valid;
  logic [CH*DW-1:0] in_data;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_wdata;
  logic             ping_we;
  logic             pong_we;
  logic             active_buf;
  logic             ping_full;
  logic             pong_full;
  logic             ping_release;
  logic             pong_release;
  logic             overrun;
  logic             overrun_clr;

  int  checks = 0;
  int  errors = 0;
  wr_t expQ[$];
  wr_t expW;
  int  modelPtr = 0;
  logic modelBuf = 1'b0;

  audio_pingpong_writer #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .EN           (EN),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ping_we      (ping_we),
    .pong_we      (pong_we),
    .active_buf   (active_buf),
    .ping_full    (ping_full),
    .pong_full    (pong_full),
    .ping_release (ping_release),
    .pong_release (pong_release),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample();
    @(negedge HCLK);
  endtask

  // Queue the words a frame should produce at the bench's own fill position.
  task automatic pushFrame(input logic [CH*DW-1:0] d);
    wr_t w;
    for (int c = 0; c < CH; c++) begin
      w.isPong = modelBuf;
      w.addr   = AW'(modelPtr);
      w.data   = d[c*DW +: DW];
      expQ.push_back(w);
      modelPtr++;
      if (modelPtr == DEPTH) begin
        modelPtr = 0;
        modelBuf = ~modelBuf;
      end
    end
  endtask

  task automatic applyStimulus(input logic [CH*DW-1:0] d, input bit expectAccept, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    if (expectAccept) pushFrame(d);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_addr"},    64'(ram_addr),   64'd0);
    checkOutput({tag, "_wdata"},   64'(ram_wdata),  64'd0);
    checkOutput({tag, "_we"},      64'({ping_we, pong_we}), 64'd0);
    checkOutput({tag, "_active"},  64'(active_buf), 64'd0);
    checkOutput({tag, "_full"},    64'({ping_full, pong_full}), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(overrun),    64'd0);
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge HCLK) begin
    if (HRESETn && (ping_we || pong_we)) begin
      checkOutput("we_exclusive", 64'(ping_we & pong_we), 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("we_without_expect", 64'({pong_we, ping_we}), 64'd0);
      end else begin
        expW = expQ.pop_front();
        checkOutput("write", 64'({pong_we, ram_addr, ram_wdata}), 64'(expW));
      end
    end
  end

  initial begin
    HRESETn      = 1'b0;
    EN           = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    ping_release = 1'b0;
    pong_release = 1'b0;
    overrun_clr  = 1'b0;

    repeat (3) @(posedge HCLK);
    sample();
    checkResetState("reset");
    tick();
    HRESETn = 1'b1;
    EN      = 1'b1;
    tick();

    // First frame lands in ping at addresses 0 and 1, channel 0 first.
    applyStimulus(32'hBBBB_AAAA, 1'b1, 2);
    sample();
    checkOutput("t1_overrun", 64'(overrun), 64'd0);

    // Fill ping: after the 8th word ping is full and pong becomes active.
    applyStimulus(32'h0002_0001, 1'b1, 2);
    applyStimulus(32'h0004_0003, 1'b1, 2);
    applyStimulus(32'h0006_0005, 1'b1, 2);
    sample();
    checkOutput("t2_ping_full", 64'(ping_full),  64'd1);
    checkOutput("t2_active",    64'(active_buf), 64'd1);
    checkOutput("t2_pong_full", 64'(pong_full),  64'd0);

    // Fill pong as well.
    applyStimulus(32'h1102_1101, 1'b1, 2);
    applyStimulus(32'h1104_1103, 1'b1, 2);
    applyStimulus(32'h1106_1105, 1'b1, 2);
    applyStimulus(32'h1108_1107, 1'b1, 2);
    sample();
    checkOutput("t3_both_full", 64'({ping_full, pong_full}), 64'b11);
    checkOutput("t3_active",    64'(active_buf), 64'd0);
    checkOutput("t3_no_overrun", 64'(overrun),   64'd0);

    // Both halves full: the frame is lost and flagged.
    applyStimulus(32'hDEAD_BEEF, 1'b0, 2);
    sample();
    checkOutput("t3_overrun", 64'(overrun), 64'd1);

    ping_release = 1'b1;
    tick();
    ping_release = 1'b0;
    sample();
    checkOutput("t3_ping_released", 64'(ping_full), 64'd0);
    checkOutput("t3_pong_still",    64'(pong_full), 64'd1);

    // Writing resumes at ping address 0.
    applyStimulus(32'h2202_2201, 1'b1, 2);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    sample();
    checkOutput("t3_overrun_clr", 64'(overrun), 64'd0);

    // Back-to-back strobes: the second arrives during WRITE and is dropped.
    applyStimulus(32'h3302_3301, 1'b1, 0);
    applyStimulus(32'h3304_3303, 1'b0, 2);
    sample();
    checkOutput("t4_overrun", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    sample();
    checkOutput("t4_overrun_clr", 64'(overrun), 64'd0);

    // Clear coincident with a new drop: the set must win.
    in_valid = 1'b1;
    in_data  = 32'h4402_4401;
    pushFrame(32'h4402_4401);
    tick();
    in_data     = 32'h4404_4403;
    overrun_clr = 1'b1;
    tick();
    in_valid    = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    sample();
    checkOutput("t4_set_wins", 64'(overrun), 64'd1);

    pong_release = 1'b1;
    tick();
    pong_release = 1'b0;
    sample();
    checkOutput("t4_pong_released", 64'(pong_full), 64'd0);

    // Reset in the middle of a frame, after five words of this sequence.
    applyStimulus(32'h5502_5501, 1'b1, 2);
    applyStimulus(32'h5504_5503, 1'b1, 2);
    in_valid = 1'b1;
    in_data  = 32'h5506_5505;
    expW.isPong = modelBuf;
    expW.addr   = AW'(modelPtr);
    expW.data   = 16'h5505;
    expQ.push_back(expW);
    tick();
    in_valid = 1'b0;
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    checkResetState("t6_async");
    checkOutput("t6_queue_drained", 64'(expQ.size()), 64'd0);
    expQ.delete();
    modelPtr = 0;
    modelBuf = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();

    // First frame after reset goes to ping 0; EN drops during its second
    // word but the frame still completes.
    in_valid = 1'b1;
    in_data  = 32'h6602_6601;
    pushFrame(32'h6602_6601);
    tick();
    in_valid = 1'b0;
    tick();
    EN = 1'b0;
    tick();
    tick();
    applyStimulus(32'h7777_7777, 1'b0, 2);
    sample();
    checkOutput("t5_silent_drop", 64'(overrun), 64'd0);
    EN = 1'b1;
    applyStimulus(32'h6604_6603, 1'b1, 2);

    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge HCLK);
    sample();
    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("final_overrun",     64'(overrun),     64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_pingpong_writer.md
Name: audio_pingpong_writer

Overview:
- Parametrised successor to the single-channel ping-pong sample writer.
- Accepts multi-channel PCM frames from the PDM deserializer stage.
- Serialises each frame into a dual-half (ping/pong) RAM, one word per cycle.
- Tracks per-half full/release handshakes with the consumer (DMA/AHB reader) and flags overruns instead of overwriting unread data.

Parameters:
DATA_WIDTH, 16, bits per sample word
CHANNELS, 2, samples per frame (1..8); channel 0 is written first
BUF_DEPTH, 2048, words per half; power of two and a multiple of CHANNELS
ADDR_WIDTH, $clog2(BUF_DEPTH), derived localparam, not overridable

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
EN  in  1  capture enable
in_valid  in  1  one-cycle frame strobe from deserializer; no backpressure
in_data  in  CHANNELS*DATA_WIDTH  frame; channel n at bits [n*DATA_WIDTH +: DATA_WIDTH]
ram_addr  out  ADDR_WIDTH  word address within the active half
ram_wdata  out  DATA_WIDTH  write data
ping_we  out  1  write strobe, ping half
pong_we  out  1  write strobe, pong half
active_buf  out  1  0 = ping being filled, 1 = pong
ping_full  out  1  ping half complete, awaiting consumer
pong_full  out  1  pong half complete, awaiting consumer
ping_release  in  1  pulse from consumer: ping half drained
pong_release  in  1  pulse from consumer: pong half drained
overrun  out  1  sticky: frame dropped while capture was enabled
overrun_clr  in  1  clears overrun

Behaviour:
- Reset values: ram_addr=0, ram_wdata=0, ping_we=pong_we=0, active_buf=0, ping_full=pong_full=0, overrun=0, FSM=IDLE, frame register=0.
- Reset is honoured mid-frame. Any partial half is discarded and writing restarts at ping address 0.
- FSM states: IDLE and WRITE.
- Frame acceptance (IDLE only):
  - Accepted when in_valid & EN & full flag of active half == 0.
  - Frame is latched, channel counter = 0, transition to WRITE.
- Frame drop:
  - in_valid in IDLE with EN=1 and active half full, or in_valid while in WRITE: frame dropped, overrun set next cycle.
  - in_valid with EN=0: frame dropped silently, no overrun.
- WRITE:
  - One word per cycle. ram_wdata = channel[cnt], ram_addr = current pointer.
  - Exactly one of ping_we/pong_we is high, selected by active_buf.
  - Pointer increments after each word.
  - After CHANNELS words, return to IDLE.
  - Latency: strobe at cycle k produces writes at cycles k+1 … k+CHANNELS. Minimum frame spacing is CHANNELS+1 cycles.
- Half boundary (last word written at address BUF_DEPTH-1):
  - Next cycle: full flag of that half = 1, active_buf toggles, pointer wraps to 0.
  - BUF_DEPTH % CHANNELS == 0, so a frame never straddles halves.
- EN deasserted mid-frame: the current frame completes. The pointer is held, so capture resumes contiguously.
- Release: a release pulse clears the matching full flag next cycle.
  - Release of a half that is not full is ignored.
  - Set and release of the same half cannot coincide, since only a non-full half is written. If both halves are releasing simultaneously, clear both.
- Both halves full: frames are dropped with overrun until the active half is released. Writing then resumes at address 0 of that half.
- overrun_clr and a new drop in the same cycle: set wins.
- ping_we & pong_we is never 1. Outputs are registered; there are no combinational paths from inputs to write strobes.

Decomposition:
- Shared package audio_pkg holds:
  - default DATA_WIDTH, CHANNELS and BUF_DEPTH constants;
  - state typedef {IDLE, WRITE};
  - a function that checks BUF_DEPTH % CHANNELS at elaboration.
- One natural sub-module: frame_serializer, which latches the frame and emits CHANNELS words with a last-word flag. The top level owns the pointer, half select, full flags and overrun.

Test Plan:
1. CHANNELS=2, BUF_DEPTH=8. Reset, EN=1, in_valid with in_data=0xBBBB_AAAA -> ping_we at addr 0 data 0xAAAA, then addr 1 data 0xBBBB. overrun=0.
2. Four frames spaced 3 cycles apart -> ping_full=1 after 8th word, active_buf=1, next frame written to pong addr 0.
3. Eight frames with no release -> ping_full=pong_full=1, 9th frame dropped, overrun=1, no we pulses. ping_release -> ping_full=0, 10th frame written at ping addr 0.
4. in_valid pulses on consecutive cycles -> second frame dropped, overrun=1. overrun_clr -> 0. Overrun_clr coincident with new drop -> stays 1.
5. EN=0 during the second word of a frame -> frame completes. Subsequent in_valid ignored with overrun=0. EN=1 resumes at addr 2.
6. HRESETn low during WRITE after 5 words -> all outputs return to reset values immediately. After release, first frame goes to ping addr 0.
